pt_check: RTL and testbench
===========================

# pt_check

Plaintext validator that consumes the length-prefixed message written into plaintext memory by the ARC4 PRGA stage. On request it reads the message length from address 0, then reads each character and checks that it is printable ASCII within a configurable range. It reports pass/fail and the first offending address, and is the key-acceptance test in the brute-force cracking datapath. The block is read-only: it never writes plaintext memory.

## Interface
- LO, default 8'h20: lowest acceptable character value, inclusive.
- HI, default 8'h7E: highest acceptable character value, inclusive.

- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- en  input  1  start request; sampled only while rdy=1.
- rdy  output  1  idle and able to accept en.
- done  output  1  one-cycle pulse marking completion of a check.
- valid  output  1  result of the last completed check: 1 = all characters in [LO,HI].
- bad_addr  output  8  address of the first failing character; 0 when valid=1.
- pt_addr  output  8  plaintext memory read address.
- pt_rddata  input  8  plaintext memory read data, synchronous with 1-cycle latency (address at edge N, data valid after edge N+1).

## Operation
- Memory layout:
  - PT[0] = length L (0..255).
  - Characters occupy PT[1..L].
- Internal registers: len[7:0], i[7:0], ok.
- IDLE:
  - rdy=1, pt_addr=0.
  - en=1 → READ_LEN. On that edge: rdy←0, valid←0, bad_addr←0.
- READ_LEN: pt_addr=0 → LATCH_LEN.
- LATCH_LEN:
  - len←pt_rddata, i←1.
  - If pt_rddata==0: ok←1 → FINISH.
  - Otherwise → REQ.
- REQ: pt_addr=i → CMP.
- CMP: pt_addr stays at i; pt_rddata is PT[i].
  - PT[i]<LO or PT[i]>HI: ok←0, bad_addr←i → FINISH.
  - Otherwise, if i==len: ok←1 → FINISH.
  - Otherwise: i←i+1 → REQ.
- FINISH → IDLE. On that edge: valid←ok, rdy←1, done←1.
- done is high only during the first IDLE cycle; it clears on the following edge.
- The i==len comparison happens before any increment, so i never wraps; L=255 checks PT[1..255].
- Range checks are unsigned 8-bit. Characters equal to LO or HI pass.
- Scanning stops at the first failure; remaining characters are not read.

## Timing
- Reset values: rdy=1, done=0, valid=0, bad_addr=0, pt_addr=0, state IDLE.
- Reset asserted in any state: IDLE with reset values after that edge. An in-progress check is abandoned and its result is not reported.
- en while rdy=0 is ignored, not queued.
- en held high: a new check is accepted in the same cycle rdy and done are high. done still pulses, and valid from the finished job is visible for that one cycle before clearing.
- Latency, counting edges from the accepting edge (edge 0):
  - All L characters pass (including L=0): rdy returns high after edge 2L+3.
  - First failure at character k: rdy returns high after edge 2k+3.
- valid and bad_addr are stable from the done cycle until the next accepted en.
- pt_addr changes only on clock edges and never exceeds len.

## Test plan
- Reset: hold rst for 2 cycles with en=1 → rdy=1, done=0, valid=0, bad_addr=0, pt_addr=0. No start occurs during reset.
- All pass: PT = {5,"Hello"}, pulse en → done after edge 13, valid=1, bad_addr=0. Highest address read is 5.
- Failure: PT = {4,'a',8'h0A,'b','c'}, pulse en → done after edge 7, valid=0, bad_addr=2. PT[3] and PT[4] are never addressed.
- Boundaries:
  - L=0 → valid=1 after edge 3.
  - {2,8'h20,8'h7E} → valid=1.
  - {2,8'h1F,'x'} → valid=0, bad_addr=1.
  - {1,8'h7F} → valid=0, bad_addr=1.
- Maximum length: L=255, all 'A' → valid=1 after edge 513. Confirm i does not wrap.
- Reset and en handling:
  - Assert rst at edge 6 of a 10-character check → IDLE with reset outputs next cycle.
  - A subsequent en is accepted normally.
  - en pulses while busy are ignored.

Source files
------------

// File: rtl/pt_check_if.sv
// pt_check bus: start handshake, result, and plaintext read port.
// The slave side is the checker; the master side owns en and memory data.
interface pt_check_if;
  logic       en;
  logic       rdy;
  logic       done;
  logic       valid;
  logic [7:0] bad_addr;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;

  modport master (
    output en,
    output pt_rddata,
    input  rdy,
    input  done,
    input  valid,
    input  bad_addr,
    input  pt_addr
  );

  modport slave (
    input  en,
    input  pt_rddata,
    output rdy,
    output done,
    output valid,
    output bad_addr,
    output pt_addr
  );
endinterface

// File: rtl/pt_check.sv
// Plaintext validator: reads length-prefixed message, checks each
// character lies in [LO,HI], reports pass/fail and first bad address.
module pt_check #(
  parameter logic [7:0] LO = 8'h20,
  parameter logic [7:0] HI = 8'h7E
) (
  input logic      clk,
  input logic      rst,
  pt_check_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] READ_LEN  = 3'd1;
  localparam logic [2:0] LATCH_LEN = 3'd2;
  localparam logic [2:0] REQ       = 3'd3;
  localparam logic [2:0] CMP       = 3'd4;
  localparam logic [2:0] FINISH    = 3'd5;

  logic [2:0] state;
  logic [7:0] len;
  logic [7:0] i;
  logic       ok;
  logic       rdy;
  logic       done;
  logic       valid;
  logic [7:0] bad_addr;
  logic [7:0] pt_addr;
  logic       out_of_range;

  assign bus.rdy      = rdy;
  assign bus.done     = done;
  assign bus.valid    = valid;
  assign bus.bad_addr = bad_addr;
  assign bus.pt_addr  = pt_addr;

  // Unsigned range test on the character currently on the read port.
  always_comb begin
    out_of_range = (bus.pt_rddata < LO) || (bus.pt_rddata > HI);
  end

  // Scan FSM; pt_addr is registered so it only moves on clock edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len      <= 8'd0;
      i        <= 8'd0;
      ok       <= 1'b0;
      rdy      <= 1'b1;
      done     <= 1'b0;
      valid    <= 1'b0;
      bad_addr <= 8'd0;
      pt_addr  <= 8'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.en) begin
            state    <= READ_LEN;
            rdy      <= 1'b0;
            valid    <= 1'b0;
            bad_addr <= 8'd0;
            pt_addr  <= 8'd0;
          end
        end
        READ_LEN: begin
          state <= LATCH_LEN;
        end
        LATCH_LEN: begin
          len <= bus.pt_rddata;
          i   <= 8'd1;
          if (bus.pt_rddata == 8'd0) begin
            ok    <= 1'b1;
            state <= FINISH;
          end else begin
            pt_addr <= 8'd1;
            state   <= REQ;
          end
        end
        REQ: begin
          state <= CMP;
        end
        CMP: begin
          if (out_of_range) begin
            ok       <= 1'b0;
            bad_addr <= i;
            pt_addr  <= 8'd0;
            state    <= FINISH;
          end else if (i == len) begin
            ok      <= 1'b1;
            pt_addr <= 8'd0;
            state   <= FINISH;
          end else begin
            i       <= i + 8'd1;
            pt_addr <= i + 8'd1;
            state   <= REQ;
          end
        end
        FINISH: begin
          valid <= ok;
          rdy   <= 1'b1;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pt_check.sv
// Directed bench for pt_check with a 1-cycle-latency plaintext memory.
// Each step drives at negedge and checks outputs at negedge.
module tb_pt_check;

  logic clk;
  logic rst;
  logic clr;
  logic [7:0] mem [256];
  logic [7:0] max_addr;
  int errors;
  int checks;
  int n;

  pt_check_if bus();

  pt_check dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.pt_rddata <= mem[bus.pt_addr];

  always @(posedge clk) begin
    if (clr) max_addr <= 8'd0;
    else if (bus.pt_addr > max_addr) max_addr <= bus.pt_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int l, input logic [7:0] c);
    for (int k = 0; k < 256; k++) mem[k] = 8'h41;
    mem[0] = l[7:0];
    for (int k = 1; k <= l; k++) mem[k] = c;
  endtask

  task automatic wait_rdy(output int cnt);
    cnt = 0;
    while (cnt < 600) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (bus.rdy) break;
    end
  endtask

  task automatic run(input string tag, input int exp_edges,
                     input logic exp_valid, input logic [7:0] exp_bad,
                     input logic [7:0] exp_max, input bit poke);
    int c;
    @(negedge clk);
    clr = 1'b1;
    bus.en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    bus.en = 1'b0;
    c = 0;
    while (c < 600) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (poke && c == 3) bus.en = 1'b1;
      if (poke && c == 4) bus.en = 1'b0;
      if (bus.rdy) break;
    end
    chk({tag, " edges"}, c, exp_edges);
    chk({tag, " done"}, bus.done, 1'b1);
    chk({tag, " valid"}, bus.valid, exp_valid);
    chk({tag, " bad_addr"}, bus.bad_addr, exp_bad);
    chk({tag, " max_addr"}, max_addr, exp_max);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done clr"}, bus.done, 1'b0);
    chk({tag, " rdy idle"}, bus.rdy, 1'b1);
    chk({tag, " valid hold"}, bus.valid, exp_valid);
  endtask

  initial begin
    string s;
    errors = 0;
    checks = 0;
    clr = 1'b1;
    bus.en = 1'b1;
    rst = 1'b1;
    fill(0, 8'h41);

    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst rdy", bus.rdy, 1'b1);
      chk("rst done", bus.done, 1'b0);
      chk("rst valid", bus.valid, 1'b0);
      chk("rst bad", bus.bad_addr, 8'd0);
      chk("rst addr", bus.pt_addr, 8'd0);
    end
    rst = 1'b0;
    bus.en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post rst idle", bus.rdy, 1'b1);

    s = "Hello";
    fill(5, 8'h41);
    for (int k = 0; k < 5; k++) mem[k+1] = s[k];
    run("hello", 13, 1'b1, 8'd0, 8'd5, 1'b0);

    fill(4, 8'h61);
    mem[2] = 8'h0A;
    mem[3] = 8'h62;
    mem[4] = 8'h63;
    run("fail2", 7, 1'b0, 8'd2, 8'd2, 1'b0);

    fill(0, 8'h41);
    run("len0", 3, 1'b1, 8'd0, 8'd0, 1'b0);

    fill(2, 8'h20);
    mem[2] = 8'h7E;
    run("edges ok", 7, 1'b1, 8'd0, 8'd2, 1'b0);

    fill(2, 8'h1F);
    mem[2] = 8'h78;
    run("below lo", 5, 1'b0, 8'd1, 8'd1, 1'b0);

    fill(1, 8'h7F);
    run("above hi", 5, 1'b0, 8'd1, 8'd1, 1'b0);

    fill(255, 8'h41);
    run("len255", 513, 1'b1, 8'd0, 8'd255, 1'b0);

    fill(3, 8'h5A);
    run("busy en", 9, 1'b1, 8'd0, 8'd3, 1'b1);

    fill(10, 8'h61);
    mem[9] = 8'h00;
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst rdy", bus.rdy, 1'b1);
    chk("midrst done", bus.done, 1'b0);
    chk("midrst valid", bus.valid, 1'b0);
    chk("midrst bad", bus.bad_addr, 8'd0);
    chk("midrst addr", bus.pt_addr, 8'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst no done", bus.done, 1'b0);
    run("after rst", 21, 1'b0, 8'd9, 8'd9, 1'b0);

    fill(1, 8'h61);
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    wait_rdy(n);
    chk("held edges", n, 5);
    chk("held done", bus.done, 1'b1);
    chk("held valid", bus.valid, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    chk("held accept rdy", bus.rdy, 1'b0);
    chk("held accept valid", bus.valid, 1'b0);
    chk("held accept done", bus.done, 1'b0);
    wait_rdy(n);
    chk("held2 edges", n, 5);
    chk("held2 valid", bus.valid, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
